psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream neighbour of the PE multiplier. Consumes the multiplier's product stream, sums cfg_acc_len products into one partial sum (psum), optionally adds a psum from the upstream PE, and emits the result over a valid/ready handshake.
- Drives a stall back to the multiplier; the multiplier's en is tied to ~stall_out, so products are never produced while the block cannot take them.

Parameters:
- PROD_WIDTH, 32, width of the multiplier product (unsigned).
- PSUM_WIDTH, 40, width of the accumulator, psum_in and psum_out; must be >= PROD_WIDTH.
- CNT_WIDTH, 8, width of the product counter and cfg_acc_len.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_acc_len  in  CNT_WIDTH  number of products per psum; 0 is treated as 1.
- cfg_use_psum_in  in  1  1 = add one upstream psum before output.
- prod_in  in  PROD_WIDTH  product from the multiplier.
- prod_valid  in  1  prod_in is valid this cycle.
- stall_out  out  1  1 = block cannot accept products; multiplier en = ~stall_out.
- psum_in  in  PSUM_WIDTH  upstream psum.
- psum_in_valid  in  1  upstream psum valid.
- psum_in_ready  out  1  block accepts psum_in this cycle.
- psum_out  out  PSUM_WIDTH  completed psum.
- psum_out_valid  out  1  psum_out valid.
- psum_out_ready  in  1  downstream accepts psum_out.
- acc_count  out  CNT_WIDTH  number of products accumulated in the current psum.
- err_drop  out  1  sticky; a product arrived while stall_out = 1.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state = ACCUM; accumulator, acc_count, psum_out and err_drop = 0.
  - stall_out = 0, psum_in_ready = 0, psum_out_valid = 0.
- Arithmetic:
  - All values are unsigned. prod_in is zero-extended to PSUM_WIDTH.
  - Sums wrap modulo 2^PSUM_WIDTH; there is no saturation.
- Configuration:
  - cfg_acc_len and cfg_use_psum_in are latched on the cycle the first product of a psum is accepted (acc_count = 0).
  - Changes to either input while acc_count > 0 have no effect until the next psum.
- State ACCUM:
  - stall_out = 0.
  - When prod_valid = 1:
    - If acc_count = 0, acc <= prod_in; otherwise acc <= acc + prod_in.
    - acc_count increments.
  - When the accepted product is the Nth (N = latched length, minimum 1):
    - Next state is WAIT_PSUM if cfg_use_psum_in = 1, otherwise OUTPUT.
    - acc_count holds at N.
  - prod_valid = 0 leaves everything unchanged.
- State WAIT_PSUM:
  - stall_out = 1, psum_in_ready = 1.
  - When psum_in_valid = 1: acc <= acc + psum_in, next state = OUTPUT.
- State OUTPUT:
  - stall_out = 1, psum_out_valid = 1, psum_out = acc, held stable while psum_out_ready = 0.
  - When psum_out_ready = 1: next state = ACCUM, acc_count = 0, psum_out_valid drops the next cycle.
- Latency:
  - Without psum_in, the last product is accepted at edge t and psum_out_valid = 1 from t+1.
  - With psum_in valid immediately, psum_out_valid = 1 from t+2.
  - Back-to-back psums: the first product of the next psum can be accepted in the cycle after the output handshake.
- stall_out:
  - Combinational from state only; it goes high in the cycle after the last product is accepted.
  - The pipelined multiplier may still have products in flight at that point. The PE controller must therefore not issue multiplies beyond cfg_acc_len per psum.
  - A product arriving while stall_out = 1 is discarded, sets err_drop, and does not change acc or acc_count.
  - err_drop clears only on reset.
- psum_in_valid outside WAIT_PSUM is ignored; the psum_in value is not consumed.
- Reset asserted mid-psum or mid-handshake: immediate return to the reset state; the partial result is lost.

Test Plan:
- cfg_acc_len = 3, cfg_use_psum_in = 0; products 5, 7, 11 on consecutive cycles -> psum_out = 23, valid 1 cycle after the third product; stall_out = 1 until the handshake.
- cfg_acc_len = 2, cfg_use_psum_in = 1; products 100, 200; psum_in = 1000 delayed 4 cycles -> psum_in_ready high for those 4 cycles, then psum_out = 1300.
- psum_out_ready held 0 for 5 cycles with psum_out = 23 -> value and valid stable throughout; a prod_valid pulse during the stall sets err_drop, acc unchanged.
- PSUM_WIDTH = 40: acc = 2^40 - 2, then product 5 -> psum_out = 3 (wrap).
- cfg_acc_len = 0 and 1, single product 9 -> psum_out = 9 after one product; cfg_acc_len changed from 3 to 1 after the first product -> still accumulates 3.
- Reset pulsed during WAIT_PSUM -> all outputs return to reset values next; a new psum of products 1, 2 with cfg_acc_len = 2 -> psum_out = 3.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Sums a run of multiplier products into one partial sum, optionally adds one
// psum from the upstream PE, and presents the result on a valid/ready port.
// While a result is pending the block raises stall_out. The multiplier's
// enable is ~stall_out, so it produces no products while stall_out is high.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   cfg_acc_len       products per psum (0 behaves as 1), latched on first product
//   cfg_use_psum_in   add one upstream psum before output, latched on first product
//   prod_in/valid     product stream from the multiplier (unsigned)
//   stall_out         block cannot take products (depends on state only)
//   psum_in/valid/ready   upstream psum handshake
//   psum_out/valid/ready  result handshake toward downstream
//   acc_count         products accumulated into the current psum
//   err_drop          sticky: a product arrived while stalled and was discarded
//
// state     | meaning
// ACCUM     | taking products, stall_out low
// WAIT_PSUM | product run done, waiting for the upstream psum
// OUTPUT    | result on psum_out, waiting for psum_out_ready
module psum_accumulator #(
  parameter int PROD_WIDTH = 32,
  parameter int PSUM_WIDTH = 40,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_WIDTH-1:0]  cfg_acc_len,
  input  logic                  cfg_use_psum_in,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  output logic                  stall_out,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [CNT_WIDTH-1:0]  acc_count,
  output logic                  err_drop
);

  typedef enum logic [1:0] {ACCUM, WAIT_PSUM, OUTPUT} state_t;

  state_t                state, state_next;
  logic [PSUM_WIDTH-1:0] acc, acc_next;
  logic [CNT_WIDTH-1:0]  cnt_next, len_q, len_next;
  logic                  use_q, use_next, err_next;

  logic [PSUM_WIDTH-1:0] prod_ext;
  logic [CNT_WIDTH-1:0]  cfg_len_eff, len_target, cnt_inc;
  logic                  first, use_target;

  assign prod_ext    = PSUM_WIDTH'(prod_in);
  assign cfg_len_eff = (cfg_acc_len == '0) ? CNT_WIDTH'(1) : cfg_acc_len;
  assign first       = (acc_count == '0);
  // On the first product the live config decides the run; afterwards the
  // latched copy does, so config changes mid-psum are ignored.
  assign len_target  = first ? cfg_len_eff : len_q;
  assign use_target  = first ? cfg_use_psum_in : use_q;
  assign cnt_inc     = acc_count + CNT_WIDTH'(1);
  assign psum_out    = acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACCUM;
      acc       <= '0;
      acc_count <= '0;
      len_q     <= '0;
      use_q     <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      acc_count <= cnt_next;
      len_q     <= len_next;
      use_q     <= use_next;
      err_drop  <= err_next;
    end
  end

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    cnt_next       = acc_count;
    len_next       = len_q;
    use_next       = use_q;
    stall_out      = 1'b1;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        stall_out = 1'b0;
        if (prod_valid) begin
          acc_next = first ? prod_ext : acc + prod_ext;
          cnt_next = cnt_inc;
          if (first) begin
            len_next = cfg_len_eff;
            use_next = cfg_use_psum_in;
          end
          if (cnt_inc == len_target)
            state_next = use_target ? WAIT_PSUM : OUTPUT;
        end
      end
      WAIT_PSUM: begin
        psum_in_ready = 1'b1;
        if (psum_in_valid) begin
          acc_next   = acc + psum_in;
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          state_next = ACCUM;
          cnt_next   = '0;
        end
      end
      default: state_next = ACCUM;
    endcase
    // A product that shows up while stalled is lost; flag it until reset.
    err_next = err_drop | (prod_valid & stall_out);
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed cases plus randomized
// psums checked against a plain-arithmetic reference sum.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cfg_acc_len;
  logic        cfg_use_psum_in;
  logic [31:0] prod_in;
  logic        prod_valid;
  logic        stall_out;
  logic [39:0] psum_in;
  logic        psum_in_valid;
  logic        psum_in_ready;
  logic [39:0] psum_out;
  logic        psum_out_valid;
  logic        psum_out_ready;
  logic [7:0]  acc_count;
  logic        err_drop;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic exp_err;
  logic [31:0] prods[$];

  always #5 clk = ~clk;

  psum_accumulator #(.PROD_WIDTH(32), .PSUM_WIDTH(40), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .cfg_acc_len(cfg_acc_len), .cfg_use_psum_in(cfg_use_psum_in),
    .prod_in(prod_in), .prod_valid(prod_valid), .stall_out(stall_out),
    .psum_in(psum_in), .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
    .psum_out(psum_out), .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .acc_count(acc_count), .err_drop(err_drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Runs one psum with the products already in 'prods'. Expected result is
  // the plain modulo-2^40 sum of the first N products (+ upstream psum).
  task automatic run_psum(input string tag, input logic [7:0] len, input logic [7:0] len_after,
                          input bit use_in, input int in_delay, input logic [39:0] pin,
                          input int out_delay, input bit drop);
    int n;
    logic [39:0] exp_sum;
    n = (len == 0) ? 1 : int'(len);
    exp_sum = '0;
    for (int i = 0; i < n; i++) exp_sum += 40'(prods[i]);
    if (use_in) exp_sum += pin;
    cfg_acc_len = len;
    cfg_use_psum_in = use_in;
    for (int i = 0; i < n; i++) begin
      chk({tag, "/count"}, acc_count, i);
      chk({tag, "/stall_lo"}, stall_out, 0);
      prod_valid = 1'b1;
      prod_in = prods[i];
      psum_in_valid = 1'($urandom);
      psum_in = 40'($urandom);
      @(negedge clk);
      if (i == 0) begin
        cfg_acc_len = len_after;
        cfg_use_psum_in = ~use_in;
      end
    end
    prod_valid = 1'b0;
    psum_in_valid = 1'b0;
    chk({tag, "/count_n"}, acc_count, n);
    chk({tag, "/stall_hi"}, stall_out, 1);
    if (use_in) begin
      for (int d = 0; d < in_delay; d++) begin
        chk({tag, "/in_ready_wait"}, psum_in_ready, 1);
        chk({tag, "/valid_early"}, psum_out_valid, 0);
        @(negedge clk);
      end
      chk({tag, "/in_ready"}, psum_in_ready, 1);
      psum_in_valid = 1'b1;
      psum_in = pin;
      @(negedge clk);
      psum_in_valid = 1'b0;
      psum_in = 40'($urandom);
    end
    chk({tag, "/in_ready_lo"}, psum_in_ready, 0);
    chk({tag, "/valid"}, psum_out_valid, 1);
    chk({tag, "/psum"}, psum_out, exp_sum);
    for (int d = 0; d < out_delay; d++) begin
      psum_out_ready = 1'b0;
      if (drop && d == 0) begin
        prod_valid = 1'b1;
        prod_in = $urandom;
        exp_err = 1'b1;
      end
      @(negedge clk);
      prod_valid = 1'b0;
      chk({tag, "/hold_valid"}, psum_out_valid, 1);
      chk({tag, "/hold_psum"}, psum_out, exp_sum);
      chk({tag, "/hold_stall"}, stall_out, 1);
      chk({tag, "/hold_err"}, err_drop, exp_err);
    end
    psum_out_ready = 1'b1;
    @(negedge clk);
    psum_out_ready = 1'b0;
    chk({tag, "/valid_drop"}, psum_out_valid, 0);
    chk({tag, "/stall_rel"}, stall_out, 0);
    chk({tag, "/count_clr"}, acc_count, 0);
    chk({tag, "/err"}, err_drop, exp_err);
  endtask

  initial begin
    #1ms;
    $error("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    cfg_acc_len = 8'd0;
    cfg_use_psum_in = 1'b0;
    prod_in = '0;
    prod_valid = 1'b0;
    psum_in = '0;
    psum_in_valid = 1'b0;
    psum_out_ready = 1'b0;
    exp_err = 1'b0;
    #2;
    chk("rst/stall", stall_out, 0);
    chk("rst/in_ready", psum_in_ready, 0);
    chk("rst/valid", psum_out_valid, 0);
    chk("rst/psum", psum_out, 0);
    chk("rst/count", acc_count, 0);
    chk("rst/err", err_drop, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 5+7+11, output held 5 cycles with a dropped product during the stall
    prods.delete(); prods.push_back(5); prods.push_back(7); prods.push_back(11);
    run_psum("len3", 8'd3, 8'd3, 1'b0, 0, 40'd0, 5, 1'b1);

    // upstream psum arrives 4 cycles late
    prods.delete(); prods.push_back(100); prods.push_back(200);
    run_psum("psum_in", 8'd2, 8'd2, 1'b1, 4, 40'd1000, 0, 1'b0);

    // wrap modulo 2^40
    prods.delete(); prods.push_back(5);
    run_psum("wrap", 8'd1, 8'd1, 1'b1, 0, 40'hFF_FFFF_FFFE, 1, 1'b0);

    prods.delete(); prods.push_back(9);
    run_psum("len0", 8'd0, 8'd0, 1'b0, 0, 40'd0, 0, 1'b0);
    run_psum("len1", 8'd1, 8'd1, 1'b0, 0, 40'd0, 0, 1'b0);

    // length change after first product is ignored
    prods.delete(); prods.push_back(1); prods.push_back(2); prods.push_back(3);
    run_psum("cfg_latch", 8'd3, 8'd1, 1'b0, 0, 40'd0, 0, 1'b0);

    // reset during WAIT_PSUM
    cfg_acc_len = 8'd2;
    cfg_use_psum_in = 1'b1;
    prod_valid = 1'b1;
    prod_in = 32'd1;
    @(negedge clk);
    prod_in = 32'd2;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("rst_wait/in_ready", psum_in_ready, 1);
    reset = 1'b0;
    #1;
    chk("rst_wait/stall", stall_out, 0);
    chk("rst_wait/in_ready_lo", psum_in_ready, 0);
    chk("rst_wait/valid", psum_out_valid, 0);
    chk("rst_wait/count", acc_count, 0);
    chk("rst_wait/psum", psum_out, 0);
    chk("rst_wait/err", err_drop, 0);
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    prods.delete(); prods.push_back(1); prods.push_back(2);
    run_psum("rst_new", 8'd2, 8'd2, 1'b0, 0, 40'd0, 0, 1'b0);

    // randomized psums
    for (int k = 0; k < 24; k++) begin
      logic [7:0] len;
      len = 8'($urandom_range(0, 5));
      prods.delete();
      for (int j = 0; j < 5; j++) prods.push_back($urandom);
      run_psum("rand", len, 8'($urandom_range(0, 5)), 1'($urandom), $urandom_range(0, 3),
               40'({$urandom, $urandom}), $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
